serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  request to add; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured on accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while in RUN or DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; sum/cout valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, held until next completion.
REQ-011 SHALL have port: cout  output  1  registered carry-out, held until next completion.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, through one shared 1-bit full-adder cell, one bit per clock.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b, cin into internal registers, clear the bit counter, go to RUN; start=0 stays IDLE.
REQ-015 RUN: each edge SHALL feed a_reg[0], b_reg[0], carry_reg to the cell, shift the cell sum bit into the MSB of the result shift register, load the cell carry into carry_reg, shift a_reg/b_reg right by one, increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge SHALL go to DONE and load sum/cout from the result shift register and final carry in the same edge.
REQ-017 done SHALL be 1 exactly for the DONE cycle; DONE SHALL go to IDLE unconditionally on the next edge.
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the edge that accepted start; next start is accepted no earlier than WIDTH+2 edges after the previous one.
REQ-019 start while busy=1 SHALL be ignored, with no effect on operands, counter, or outputs.
REQ-020 Changes on a, b, cin after acceptance SHALL NOT affect the running result.
REQ-021 sum/cout SHALL change only on the RUN->DONE edge or reset; they SHALL hold otherwise.
REQ-022 Counter width SHALL be $clog2(WIDTH)+1; no wrap-around within one operation.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, and clear counter, operand, and carry registers.
REQ-024 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-026 Sub-module full_adder_cell SHALL be the combinational 1-bit adder (a, b, cin -> s, cout), instantiated once; no other arithmetic on operand bits.

Verification (WIDTH=8)
REQ-027 SHALL check: a=0x00, b=0x00, cin=0, start pulse -> done after 8 edges, sum=0x00, cout=0, busy low on the following cycle.
REQ-028 SHALL check: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=100, b=27, cin=0 -> sum=127, cout=0.
REQ-029 SHALL check: start held high with a=0x0F during RUN of 0x01+0x01 -> single done, sum=0x02, cout=0; second start accepted only after IDLE.
REQ-030 SHALL check: rst_n low at RUN cycle 4 -> sum=0, cout=0, busy=0 immediately, no done; next start with 0x10+0x20 -> sum=0x30.
REQ-031 SHALL check: all 8-entry full-adder truth-table combinations in bit 0 and a 200-vector random run against a + b + cin; all results match, done count equals start-accept count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder controller.
//   - DEFAULT_WIDTH : default operand width used by serial_adder_ctrl
//   - state_t       : controller FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
//   Combinational 1-bit full adder. The serial adder pushes every operand bit
//   through a single instance of this cell.
//   Ports:
//     a, b  : input  operand bits
//     cin   : input  carry in
//     s     : output sum bit
//     cout  : output carry out
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: {cout,sum} = a + b + cin, computed LSB first through one
//   shared full-adder cell, one bit per clock.
//
//   Flow: IDLE --start--> RUN (WIDTH edges) --> DONE (1 cycle) --> IDLE
//
//   Ports:
//     clk    : input  clock, rising edge
//     rst_n  : input  asynchronous active-low reset
//     start  : input  add request, only looked at in IDLE
//     a, b   : input  [WIDTH-1:0] operands, captured when start is accepted
//     cin    : input  carry in, captured when start is accepted
//     busy   : output high in RUN and DONE
//     done   : output one-cycle pulse, sum/cout valid
//     sum    : output [WIDTH-1:0] result, held until the next completion
//     cout   : output carry out, held until the next completion
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so the count can reach WIDTH without wrapping.
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] a_reg,     a_next;
  logic [WIDTH-1:0] b_reg,     b_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] res_reg,   res_next;
  logic [WIDTH-1:0] sum_reg,   sum_next;
  logic             cout_reg,  cout_next;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_shifted;

  // The only adder in the design; it always sees the current LSBs and carry.
  full_adder_cell u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits in res[0].
  // On the final edge the shifted value is used directly, which means the
  // current res_reg[0] (a bit about to fall off the end) is never consumed.
  assign res_shifted = {fa_s, res_reg[WIDTH-1:1]};

  logic res_lsb_unused;
  assign res_lsb_unused = res_reg[0];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      res_reg   <= res_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    res_next   = res_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          carry_next = cin;
          count_next = '0;
          res_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        carry_next = fa_c;
        res_next   = res_shifted;
        count_next = count_reg + 1'b1;
        // Last bit: publish the result in the same edge that leaves RUN.
        if (count_reg == LAST_BIT) begin
          sum_next   = res_shifted;
          cout_next  = fa_c;
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed and random checks of serial_adder_ctrl at WIDTH=8.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_cnt   = 0;
  int accept_cnt = 0;
  int abort_cnt  = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, sampling 1 time unit after each rising edge.
  // Operand inputs are scrambled meanwhile; the running result must not care.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      if (done === 1'b1) break;
    end
  endtask

  // One complete addition with start pulsed for a single cycle.
  task automatic do_add(input string name, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic tc, input logic [7:0] es, input logic ec);
    int edges;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cnt++;
    check_eq({name, " busy after accept"}, 32'(busy), 32'd1);
    wait_done(edges);
    check_eq({name, " latency"}, 32'(edges), 32'd8);
    check_eq({name, " sum"}, 32'(sum), 32'(es));
    check_eq({name, " cout"}, 32'(cout), 32'(ec));
    $display("%s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d after %0d edges",
             name, ta, tbv, tc, sum, cout, edges);
    @(posedge clk);
    #1;
    check_eq({name, " done pulse width"}, 32'(done), 32'd0);
    check_eq({name, " busy after done"}, 32'(busy), 32'd0);
    check_eq({name, " sum held"}, 32'(sum), 32'(es));
    check_eq({name, " done count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int          edges;
    int          d0;
    logic [7:0]  ta;
    logic [7:0]  tbv;
    logic        tc;
    logic [8:0]  r;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset sum",  32'(sum),  32'd0);
    check_eq("reset cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_add("zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_add("ff+01",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_add("a5+5a+1",   8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_add("100+27",    8'd100, 8'd27, 1'b0, 8'd127, 1'b0);

    // Full-adder truth table in bit 0; upper bits zero so cout is always 0
    for (int i = 0; i < 8; i++) begin
      ta  = {7'b0, i[2]};
      tbv = {7'b0, i[1]};
      tc  = i[0];
      do_add($sformatf("tt%0d", i), ta, tbv, tc, 8'(i[2] + i[1] + i[0]), 1'b0);
    end

    // start held high throughout a run: ignored while busy
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    accept_cnt++;
    a = 8'h0F;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
    end
    check_eq("hold latency", 32'(edges), 32'd8);
    check_eq("hold sum",     32'(sum),   32'h02);
    check_eq("hold cout",    32'(cout),  32'd0);
    $display("hold: a=0x01 b=0x01 cin=0 -> sum=0x%02h cout=%0d after %0d edges", sum, cout, edges);
    @(posedge clk);
    #1;
    check_eq("hold idle after done", 32'(busy), 32'd0);
    check_eq("hold single done",     32'(done_cnt - d0), 32'd1);
    check_eq("hold sum kept",        32'(sum), 32'h02);
    // start is still high: accepted now that the controller is IDLE
    @(posedge clk);
    #1;
    check_eq("hold second accept", 32'(busy), 32'd1);
    start = 1'b0;
    accept_cnt++;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
    end
    check_eq("second latency", 32'(edges), 32'd8);
    check_eq("second sum",     32'(sum),   32'h10);
    check_eq("second cout",    32'(cout),  32'd0);
    $display("hold2: a=0x0F b=0x01 cin=0 -> sum=0x%02h cout=%0d after %0d edges", sum, cout, edges);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cnt++;
    abort_cnt++;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrun reset busy", 32'(busy), 32'd0);
    check_eq("midrun reset done", 32'(done), 32'd0);
    check_eq("midrun reset sum",  32'(sum),  32'd0);
    check_eq("midrun reset cout", 32'(cout), 32'd0);
    $display("abort: a=0x33 b=0x44 reset at RUN cycle 4");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("midrun no done", 32'(done_cnt - d0), 32'd0);
    check_eq("midrun idle",    32'(busy), 32'd0);
    do_add("after reset", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Random vectors against a + b + cin
    for (int n = 0; n < 200; n++) begin
      ta  = 8'($urandom);
      tbv = 8'($urandom);
      tc  = 1'($urandom);
      r   = {1'b0, ta} + {1'b0, tbv} + {8'b0, tc};
      do_add("rnd", ta, tbv, tc, r[7:0], r[8]);
    end

    check_eq("done vs accept count", 32'(done_cnt), 32'(accept_cnt - abort_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
